// File: rtl/baudgen_frac_pkg.sv
// Shared widths, divisor constants and mode encoding for the fractional baud generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package baudgen_frac_pkg;

    localparam int BF_DIV_W   = 16;
    localparam int BF_FRAC_W  = 4;
    localparam int BF_MIN_INT = 2;   // smallest usable integer divisor

    // {int,frac} divisors for a 12 MHz clock, frac in 1/16 cycle, rounded to nearest
    localparam logic [BF_DIV_W+BF_FRAC_W-1:0] BF9600   = {16'd1250, 4'd0};
    localparam logic [BF_DIV_W+BF_FRAC_W-1:0] BF19200  = {16'd625,  4'd0};
    localparam logic [BF_DIV_W+BF_FRAC_W-1:0] BF38400  = {16'd312,  4'd8};
    localparam logic [BF_DIV_W+BF_FRAC_W-1:0] BF57600  = {16'd208,  4'd5};
    localparam logic [BF_DIV_W+BF_FRAC_W-1:0] BF115200 = {16'd104,  4'd3};

    localparam logic [BF_DIV_W+BF_FRAC_W-1:0] BF_DEFAULT_DIV = BF115200;

    typedef enum logic {
        MODE_TX = 1'b0,   // tick in first enabled cycle
        MODE_RX = 1'b1    // first tick half a bit in, for mid-bit sampling
    } mode_e;

endpackage

// File: rtl/baud_div_reg.sv
// Divisor pending/active register pair with write validation and busy/error status.
// Latency: accepted write visible on div_busy next cycle; moves to div_cur on the next apply.
// Backpressure: none; a write while busy overwrites the pending value, bad writes pulse div_err.
//
// Ports: clk, rstn (async active-low); apply (period boundary or stopped);
//        div_wr/div_in (CPU write); div_cur (active divisor), pend_int (pending integer part);
//        div_busy (pending not yet applied), div_err (one-cycle rejected-write pulse).
module baud_div_reg
    import baudgen_frac_pkg::*;
#(
    parameter int                          DIV_W       = BF_DIV_W,
    parameter int                          FRAC_W      = BF_FRAC_W,
    parameter logic [DIV_W+FRAC_W-1:0]     DEFAULT_DIV = BF_DEFAULT_DIV
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    apply,
    input  logic                    div_wr,
    input  logic [DIV_W+FRAC_W-1:0] div_in,
    output logic [DIV_W+FRAC_W-1:0] div_cur,
    output logic [DIV_W-1:0]        pend_int,
    output logic                    div_busy,
    output logic                    div_err
);

    localparam int W = DIV_W + FRAC_W;

    logic [W-1:0] pend;
    logic         wr_ok;

    assign wr_ok    = div_in[W-1:FRAC_W] >= DIV_W'(BF_MIN_INT);
    assign pend_int = pend[W-1:FRAC_W];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cur  <= DEFAULT_DIV;
            pend     <= DEFAULT_DIV;
            div_busy <= 1'b0;
            div_err  <= 1'b0;
        end else begin
            div_err <= div_wr & ~wr_ok;
            // active always takes the value pending before this edge, so a write
            // landing on an apply cycle stays pending for the next boundary
            if (apply) begin
                div_cur <= pend;
            end
            if (div_wr && wr_ok) begin
                pend     <= div_in;
                div_busy <= 1'b1;
            end else if (apply) begin
                div_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/baudgen_frac.sv
// Fractional (NCO-style) baud tick generator: period I or I+1 cycles, average I+F/2^FRAC_W.
// Latency: TX mode tick in the cycle clk_ena rises; RX mode first tick I>>1 cycles later.
// Backpressure: none; divisor changes take effect only at a period boundary or while stopped.
//
// Ports: clk, rstn (async active-low); clk_ena (run / stop+re-arm); mid (RX half-bit start,
//        sampled while stopped); div_wr/div_in (divisor write {int,frac}); div_cur (active);
//        div_busy, div_err (write status); clk_out (one-cycle bit tick, combinational).
module baudgen_frac
    import baudgen_frac_pkg::*;
#(
    parameter int                          DIV_W       = BF_DIV_W,
    parameter int                          FRAC_W      = BF_FRAC_W,
    parameter logic [DIV_W+FRAC_W-1:0]     DEFAULT_DIV = BF_DEFAULT_DIV
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clk_ena,
    input  logic                    mid,
    input  logic                    div_wr,
    input  logic [DIV_W+FRAC_W-1:0] div_in,
    output logic [DIV_W+FRAC_W-1:0] div_cur,
    output logic                    div_busy,
    output logic                    div_err,
    output logic                    clk_out
);

    localparam int W = DIV_W + FRAC_W;

    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  act_int;
    logic [DIV_W-1:0]  pend_int;
    logic [DIV_W-1:0]  nxt_int;
    logic [DIV_W-1:0]  last;
    logic [DIV_W-1:0]  hold;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W-1:0] act_frac;
    logic              ext;
    logic              at_last;
    logic              apply;
    mode_e             mode;
    mode_e             mode_nxt;

    assign act_int  = div_cur[W-1:FRAC_W];
    assign act_frac = div_cur[FRAC_W-1:0];

    // ext stretches the period by one cycle when the fractional accumulator carried
    assign last    = act_int - DIV_W'(1) + {{(DIV_W-1){1'b0}}, ext};
    assign at_last = (cnt == last);
    assign apply   = ~clk_ena | at_last;

    // The hold value must match the divisor that will be active after this edge,
    // otherwise the first RX period after a divisor change would start off-centre.
    assign nxt_int  = apply ? pend_int : act_int;
    assign mode_nxt = clk_ena ? mode : mode_e'(mid);
    assign hold     = (mode_nxt == MODE_RX) ? (nxt_int - (nxt_int >> 1)) : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt  <= '0;
            acc  <= '0;
            ext  <= 1'b0;
            mode <= MODE_TX;
        end else if (!clk_ena) begin
            cnt  <= hold;
            acc  <= '0;
            ext  <= 1'b0;
            mode <= mode_nxt;
        end else if (at_last) begin
            cnt        <= '0;
            {ext, acc} <= {1'b0, acc} + {1'b0, act_frac};
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    assign clk_out = rstn & clk_ena & (cnt == '0);

    baud_div_reg #(
        .DIV_W       (DIV_W),
        .FRAC_W      (FRAC_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_div_reg (
        .clk      (clk),
        .rstn     (rstn),
        .apply    (apply),
        .div_wr   (div_wr),
        .div_in   (div_in),
        .div_cur  (div_cur),
        .pend_int (pend_int),
        .div_busy (div_busy),
        .div_err  (div_err)
    );

endmodule

// File: tb/tb_baudgen_frac.sv
// Self-checking bench for baudgen_frac: directed scenarios plus randomized divisors.
// Expected tick times come from an unbounded fractional-phase model (cycles per period
// = I plus one whenever the accumulated fraction crosses a whole cycle).
module tb_baudgen_frac;

    localparam logic [19:0] DEF_DIV = {16'd104, 4'd3};

    logic        clk = 1'b0;
    logic        rstn;
    logic        clk_ena;
    logic        mid;
    logic        div_wr;
    logic [19:0] div_in;
    logic [19:0] div_cur;
    logic        div_busy;
    logic        div_err;
    logic        clk_out;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic        s_out;
    logic        s_busy;
    logic        s_err;
    logic [19:0] s_cur;

    int m_phase;   // total fractional units (1/16 cycle) accrued at wraps since enable
    int m_carry;   // whole cycles owed to the upcoming period

    baudgen_frac dut (
        .clk      (clk),
        .rstn     (rstn),
        .clk_ena  (clk_ena),
        .mid      (mid),
        .div_wr   (div_wr),
        .div_in   (div_in),
        .div_cur  (div_cur),
        .div_busy (div_busy),
        .div_err  (div_err),
        .clk_out  (clk_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [19:0] mk_div(input int i, input int f);
        return {i[15:0], f[3:0]};
    endfunction

    function automatic void m_start();
        m_phase = 0;
        m_carry = 0;
    endfunction

    // length of the next period with divisor i+f/16; accrues f at the closing wrap
    function automatic int m_gap(input int i, input int f);
        int g;
        g       = i + m_carry;
        m_carry = (m_phase + f) / 16 - m_phase / 16;
        m_phase = m_phase + f;
        return g;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    // sample the current cycle's outputs mid-cycle, then move just past the next edge
    task automatic tick_cycle();
        @(negedge clk);
        s_out  = clk_out;
        s_busy = div_busy;
        s_err  = div_err;
        s_cur  = div_cur;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic walk_to(input int c);
        while (cyc < c) tick_cycle();
    endtask

    task automatic expect_tick(input int at, input string tag, output int got);
        got = -1;
        while (cyc <= at) begin
            tick_cycle();
            if (s_out && got < 0) got = cyc - 1;
        end
        chk(tag, got, at);
    endtask

    task automatic write_div(input logic [19:0] d);
        div_wr = 1'b1;
        div_in = d;
        tick_cycle();
        div_wr = 1'b0;
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        clk_ena = 1'b0;
        mid     = 1'b0;
        div_wr  = 1'b0;
        div_in  = '0;
        tick_cycle();
        tick_cycle();
        chk("rst_clk_out", int'(s_out), 0);
        chk("rst_div_cur", int'(s_cur), int'(DEF_DIV));
        chk("rst_busy", int'(s_busy), 0);
        chk("rst_err", int'(s_err), 0);
        rstn = 1'b1;
    endtask

    initial begin
        int t0, nt, got, n105, ri, rf, rm, bad;
        int ticks[18];

        // 1: default divisor, TX mode
        do_reset();
        clk_ena = 1'b1;
        t0 = cyc;
        m_start();
        nt = t0;
        expect_tick(nt, "t1_first", got);
        ticks[0] = got;
        for (int k = 1; k < 18; k++) begin
            nt += m_gap(104, 3);
            expect_tick(nt, $sformatf("t1_tick%0d", k), got);
            ticks[k] = got;
        end
        n105 = 0;
        for (int k = 2; k < 18; k++) if (ticks[k] - ticks[k-1] == 105) n105++;
        chk("t1_span16", ticks[17] - ticks[1], 1667);
        chk("t1_n105", n105, 3);

        // 2: RX mode, divisor 10
        clk_ena = 1'b0;
        mid     = 1'b1;
        write_div(mk_div(10, 0));
        tick_cycle();
        tick_cycle();
        chk("t2_div_cur", int'(s_cur), int'(mk_div(10, 0)));
        chk("t2_busy", int'(s_busy), 0);
        clk_ena = 1'b1;
        t0 = cyc;
        expect_tick(t0 + 5, "t2_first", got);
        m_start();
        void'(m_gap(10, 0));
        nt = t0 + 5;
        for (int k = 0; k < 4; k++) begin
            nt += m_gap(10, 0);
            expect_tick(nt, $sformatf("t2_tick%0d", k), got);
        end

        // 3: divisor write mid-period applies only at the wrap
        do_reset();
        clk_ena = 1'b1;
        t0 = cyc;
        expect_tick(t0, "t3_first", got);
        walk_to(t0 + 50);
        write_div(mk_div(20, 8));
        tick_cycle();
        chk("t3_busy_after_wr", int'(s_busy), 1);
        walk_to(t0 + 103);
        tick_cycle();
        chk("t3_busy_wrap_cycle", int'(s_busy), 1);
        chk("t3_cur_wrap_cycle", int'(s_cur), int'(DEF_DIV));
        m_start();
        nt = t0 + m_gap(104, 3);
        expect_tick(nt, "t3_old_period", got);
        chk("t3_busy_cleared", int'(s_busy), 0);
        chk("t3_cur_new", int'(s_cur), int'(mk_div(20, 8)));
        for (int k = 0; k < 6; k++) begin
            nt += m_gap(20, 8);
            expect_tick(nt, $sformatf("t3_tick%0d", k), got);
        end

        // 4: rejected write (int=1)
        write_div(mk_div(1, 5));
        chk("t4_err_same_cycle", int'(s_err), 0);
        tick_cycle();
        chk("t4_err_pulse", int'(s_err), 1);
        chk("t4_cur_kept", int'(s_cur), int'(mk_div(20, 8)));
        chk("t4_busy_kept", int'(s_busy), 0);
        tick_cycle();
        chk("t4_err_cleared", int'(s_err), 0);

        // 5: two writes in one period, last one wins
        do_reset();
        clk_ena = 1'b1;
        t0 = cyc;
        expect_tick(t0, "t5_first", got);
        walk_to(t0 + 10);
        write_div(mk_div(30, 0));
        walk_to(t0 + 13);
        write_div(mk_div(40, 0));
        walk_to(t0 + 103);
        tick_cycle();
        chk("t5_cur_before_wrap", int'(s_cur), int'(DEF_DIV));
        chk("t5_busy_before_wrap", int'(s_busy), 1);
        m_start();
        nt = t0 + m_gap(104, 3);
        expect_tick(nt, "t5_wrap_tick", got);
        chk("t5_cur_second", int'(s_cur), int'(mk_div(40, 0)));
        nt += m_gap(40, 0);
        expect_tick(nt, "t5_next_tick", got);

        // 6: reset mid-run with a pending write
        walk_to(t0 + 150);
        write_div(mk_div(50, 0));
        tick_cycle();
        chk("t6_busy_pending", int'(s_busy), 1);
        nt += m_gap(40, 0);
        walk_to(nt);
        chk("t6_tick_before_rst", int'(clk_out), 1);
        rstn = 1'b0;
        #1;
        chk("t6_clk_out_in_rst", int'(clk_out), 0);
        chk("t6_cur_in_rst", int'(div_cur), int'(DEF_DIV));
        chk("t6_busy_in_rst", int'(div_busy), 0);
        @(posedge clk);
        #1;
        cyc++;
        rstn = 1'b1;
        t0 = cyc;
        expect_tick(t0, "t6_first_after_rst", got);
        chk("t6_cur_after_rst", int'(s_cur), int'(DEF_DIV));
        m_start();
        nt = t0 + m_gap(104, 3);
        expect_tick(nt, "t6_second_after_rst", got);

        // randomized divisors, modes and rejected writes
        for (int r = 0; r < 8; r++) begin
            ri  = $urandom_range(40, 2);
            rf  = $urandom_range(15, 0);
            rm  = $urandom_range(1, 0);
            bad = $urandom_range(1, 0);
            clk_ena = 1'b0;
            mid     = rm[0];
            write_div(mk_div(ri, rf));
            write_div(mk_div(bad, $urandom_range(15, 0)));
            tick_cycle();
            chk($sformatf("r%0d_err", r), int'(s_err), 1);
            chk($sformatf("r%0d_cur", r), int'(s_cur), int'(mk_div(ri, rf)));
            tick_cycle();
            clk_ena = 1'b1;
            t0 = cyc;
            m_start();
            if (rm != 0) begin
                nt = t0 + (ri >> 1);
                void'(m_gap(ri, rf));
            end else begin
                nt = t0;
            end
            expect_tick(nt, $sformatf("r%0d_first", r), got);
            mid = ~mid;   // must have no effect while running
            for (int k = 0; k < 12; k++) begin
                nt += m_gap(ri, rf);
                expect_tick(nt, $sformatf("r%0d_tick%0d", r, k), got);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
